// File: rtl/difftest_commit_queue.sv
// Commit-record FIFO between the core's retire stage and the difftest harness,
// with ebreak/watchdog-driven drain-then-halt sequencing and cycle/instret counters.
module difftest_commit_queue #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NCOMMIT = 2,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCOMMIT-1:0]      cmt_valid,
  input  logic [NCOMMIT*XLEN-1:0] cmt_pc,
  input  logic [NCOMMIT*32-1:0]   cmt_inst,
  input  logic [NCOMMIT-1:0]      cmt_wen,
  input  logic [NCOMMIT*5-1:0]    cmt_wdest,
  input  logic [NCOMMIT*XLEN-1:0] cmt_wdata,
  input  logic [NCOMMIT-1:0]      cmt_is_break,
  input  logic [XLEN-1:0]         a0_value,
  output logic                    cmt_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_inst,
  output logic                    out_wen,
  output logic [4:0]              out_wdest,
  output logic [XLEN-1:0]         out_wdata,
  output logic [XLEN-1:0]         out_seq,
  output logic                    halt,
  output logic [XLEN-1:0]         halt_code,
  output logic                    timeout,
  output logic                    overflow,
  output logic [XLEN-1:0]         cycle_cnt,
  output logic [XLEN-1:0]         instret
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;

  state_t          state_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [XLEN-1:0] instret_q, cycle_q, halt_code_q;
  logic            timeout_q, overflow_q;
  logic [31:0]     wd_q;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_inst  [DEPTH];
  logic            mem_wen   [DEPTH];
  logic [4:0]      mem_wdest [DEPTH];
  logic [XLEN-1:0] mem_wdata [DEPTH];
  logic [XLEN-1:0] mem_seq   [DEPTH];

  logic [PW-1:0]      count, free_cnt, n_enq;
  logic [PW-1:0]      off  [NCOMMIT];
  logic [AW-1:0]      widx [NCOMMIT];
  logic [NCOMMIT-1:0] keep;
  logic               brk_hit;
  logic               deq;
  logic [AW-1:0]      head;

  assign count     = wptr_q - rptr_q;
  assign free_cnt  = PW'(DEPTH) - count;
  assign cmt_ready = (state_q == S_RUN) && (free_cnt >= PW'(NCOMMIT));
  assign out_valid = (count != '0) && (state_q != S_HALT);
  assign deq       = out_valid && out_ready;
  assign head      = rptr_q[AW-1:0];

  // Compact valid lanes into consecutive slots; the first ebreak lane closes the group.
  always_comb begin
    keep    = '0;
    brk_hit = 1'b0;
    n_enq   = '0;
    for (int unsigned i = 0; i < NCOMMIT; i++) begin
      off[i]  = n_enq;
      widx[i] = wptr_q[AW-1:0] + n_enq[AW-1:0];
      if (cmt_valid[i] && !brk_hit) begin
        keep[i] = 1'b1;
        n_enq   = n_enq + PW'(1);
        brk_hit = cmt_is_break[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cmt_ready) begin
      for (int unsigned i = 0; i < NCOMMIT; i++) begin
        if (keep[i]) begin
          mem_pc[widx[i]]    <= cmt_pc[i*XLEN +: XLEN];
          mem_inst[widx[i]]  <= cmt_inst[i*32 +: 32];
          mem_wen[widx[i]]   <= cmt_wen[i];
          mem_wdest[widx[i]] <= cmt_wdest[i*5 +: 5];
          mem_wdata[widx[i]] <= cmt_wdata[i*XLEN +: XLEN];
          mem_seq[widx[i]]   <= instret_q + XLEN'(off[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      wptr_q      <= '0;
      rptr_q      <= '0;
      instret_q   <= '0;
      cycle_q     <= '0;
      halt_code_q <= '0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      wd_q        <= '0;
    end else begin
      if (deq) rptr_q <= rptr_q + PW'(1);
      if (cmt_ready) begin
        wptr_q    <= wptr_q + n_enq;
        instret_q <= instret_q + XLEN'(n_enq);
      end
      if ((cmt_valid != '0) && !cmt_ready) overflow_q <= 1'b1;
      if (state_q != S_HALT) cycle_q <= cycle_q + XLEN'(1);

      unique case (state_q)
        S_RUN: begin
          // Break is checked first so a coincident watchdog expiry never flags timeout.
          if (cmt_ready && brk_hit) begin
            halt_code_q <= a0_value;
            state_q     <= S_DRAIN;
          end else if (cmt_ready && (n_enq != '0)) begin
            wd_q <= '0;
          end else if ((TIMEOUT != 0) && (wd_q == 32'(TIMEOUT - 1))) begin
            timeout_q <= 1'b1;
            state_q   <= S_DRAIN;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        S_DRAIN: if (count == '0) state_q <= S_HALT;
        default: ;
      endcase
    end
  end

  assign out_pc    = out_valid ? mem_pc[head]    : '0;
  assign out_inst  = out_valid ? mem_inst[head]  : '0;
  assign out_wen   = out_valid && mem_wen[head];
  assign out_wdest = out_valid ? mem_wdest[head] : '0;
  assign out_wdata = out_valid ? mem_wdata[head] : '0;
  assign out_seq   = out_valid ? mem_seq[head]   : '0;
  assign halt      = (state_q == S_HALT);
  assign halt_code = halt_code_q;
  assign timeout   = timeout_q;
  assign overflow  = overflow_q;
  assign cycle_cnt = cycle_q;
  assign instret   = instret_q;

endmodule
